// File: rtl/frame_sequencer.sv
// Frame sequencer for the serial LED chain: per-pixel read/load/shift,
// calculator handshake and inter-frame gap, with continuous/single-shot modes.
module frame_sequencer #(
   parameter int NUM_PIXELS     = 64,
   parameter int BITS_PER_PIXEL = 24,
   parameter int CYCLES_PER_BIT = 15,
   parameter int GAP_CYCLES     = 1500000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          single_shot,
   input  logic                          frame_req,
   input  logic                          calc_done,
   output logic                          start_calc,
   output logic                          load_sreg,
   output logic                          transmit_pixel,
   output logic [$clog2(NUM_PIXELS)-1:0] pixel,
   output logic                          frame_done,
   output logic                          busy,
   output logic [1:0]                    state_o
);

   localparam int PW        = $clog2(NUM_PIXELS);
   localparam int SHIFT_LEN = BITS_PER_PIXEL * CYCLES_PER_BIT;
   localparam int SW        = $clog2(SHIFT_LEN + 1);
   localparam int GW        = $clog2(GAP_CYCLES + 1);

   localparam logic [1:0] STOP     = 2'b00;
   localparam logic [1:0] TRANSMIT = 2'b01;
   localparam logic [1:0] CALC     = 2'b10;
   localparam logic [1:0] WAIT     = 2'b11;

   localparam logic [1:0] READ  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   localparam logic [PW-1:0] LAST_PIX   = PW'(NUM_PIXELS - 1);
   localparam logic [SW-1:0] LAST_SHIFT = SW'(SHIFT_LEN - 1);
   localparam logic [GW-1:0] LAST_GAP   = GW'(GAP_CYCLES - 1);

   logic [1:0]    state;
   logic [1:0]    phase;
   logic [SW-1:0] shift_cnt;
   logic [GW-1:0] gap_cnt;
   logic          pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= STOP;
         phase      <= READ;
         pixel      <= '0;
         shift_cnt  <= '0;
         gap_cnt    <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         start_calc <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         start_calc <= 1'b0;
         unique case (state)
            STOP: begin
               if (enable && (!single_shot || frame_req || pending)) begin
                  state   <= TRANSMIT;
                  pending <= 1'b0;
               end
            end
            TRANSMIT: begin
               case (phase)
                  READ:    phase <= LOAD;
                  LOAD:    phase <= SHIFT;
                  default: begin
                     if (shift_cnt == LAST_SHIFT) begin
                        shift_cnt <= '0;
                        phase     <= READ;
                        if (pixel == LAST_PIX) begin
                           pixel      <= '0;
                           state      <= CALC;
                           frame_done <= 1'b1;
                           start_calc <= 1'b1;
                        end else begin
                           pixel <= pixel + 1'b1;
                        end
                     end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                     end
                  end
               endcase
            end
            CALC: begin
               if (calc_done) state <= WAIT;
            end
            WAIT: begin
               if (gap_cnt == LAST_GAP) begin
                  gap_cnt <= '0;
                  if (enable && (!single_shot || pending)) begin
                     state   <= TRANSMIT;
                     pending <= 1'b0;
                  end else begin
                     state <= STOP;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
         endcase
         // a request arriving on a restart edge is kept for the next frame
         if (state != STOP && frame_req) pending <= 1'b1;
      end
   end

   assign load_sreg      = (state == TRANSMIT) && (phase == LOAD);
   assign transmit_pixel = (state == TRANSMIT) && (phase == SHIFT);
   assign busy           = (state != STOP);
   assign state_o        = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a timeline model predicts strobe
// events and per-cycle status; a negedge monitor compares them to the DUT.
module tb_frame_sequencer;

   localparam int NP     = 4;
   localparam int B      = 3;
   localparam int C      = 2;
   localparam int GAP    = 5;
   localparam int PIXCYC = 2 + B * C;
   localparam int FRAME  = NP * PIXCYC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       single_shot = 1'b0;
   logic       frame_req = 1'b0;
   logic       calc_done = 1'b0;
   logic       start_calc, load_sreg, transmit_pixel, frame_done, busy;
   logic [1:0] pixel;
   logic [1:0] state_o;

   frame_sequencer #(
      .NUM_PIXELS(NP), .BITS_PER_PIXEL(B),
      .CYCLES_PER_BIT(C), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot),
      .frame_req(frame_req), .calc_done(calc_done), .start_calc(start_calc),
      .load_sreg(load_sreg), .transmit_pixel(transmit_pixel), .pixel(pixel),
      .frame_done(frame_done), .busy(busy), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit done;
      int pix;
   } ev_t;

   ev_t q[$];
   int  n_vec = 0;
   int  n_mis = 0;
   int  cyc = 0;

   // model: 0 idle, 1 transmitting, 2 calculating, 3 gap
   int  m_mode = 0;
   int  t_start = 0;
   int  g_end = 0;
   bit  pend = 0;

   int  calc_delay = 0;
   bit  noise = 0;
   bit  resp_on = 0;
   int  cd_cnt = -1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   initial begin : model
      int  n;
      int  old;
      bit  start;
      ev_t e;
      forever begin
         @(posedge clk);
         cyc++;
         n = cyc;
         if (rst) begin
            m_mode = 0;
            pend   = 0;
            q.delete();
         end else begin
            old   = m_mode;
            start = 0;
            case (old)
               0: if (enable && (!single_shot || frame_req || pend)) start = 1;
               1: if (n == t_start + FRAME) m_mode = 2;
               2: if (calc_done) begin
                     m_mode = 3;
                     g_end  = n + GAP;
                  end
               default: if (n == g_end) begin
                     if (enable && (!single_shot || pend)) start = 1;
                     else m_mode = 0;
                  end
            endcase
            if (start) begin
               m_mode  = 1;
               t_start = n;
               pend    = 0;
               for (int p = 0; p < NP; p++) begin
                  e.cyc = n + 1 + PIXCYC * p; e.done = 0; e.pix = p;
                  q.push_back(e);
               end
               e.cyc = n + FRAME; e.done = 1; e.pix = 0;
               q.push_back(e);
            end
            if (old != 0 && frame_req) pend = 1;
         end
      end
   end

   initial begin : monitor
      int  off;
      bit  has_exp;
      bit  has_dut;
      ev_t e;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            off = cyc - t_start;
            chk("state", int'(state_o), m_mode);
            chk("busy", int'(busy), int'(m_mode != 0));
            chk("pixel", int'(pixel), (m_mode == 1) ? off / PIXCYC : 0);
            chk("transmit", int'(transmit_pixel),
                int'(m_mode == 1 && (off % PIXCYC) >= 2));
            while (q.size() > 0 && q[0].cyc < cyc) begin
               chk("stale_event", 0, q[0].cyc);
               void'(q.pop_front());
            end
            has_exp = (q.size() > 0) && (q[0].cyc == cyc);
            has_dut = load_sreg || frame_done || start_calc;
            if (has_exp || has_dut) begin
               if (!has_exp) begin
                  chk("unexpected_load", int'(load_sreg), 0);
                  chk("unexpected_done", int'(frame_done), 0);
                  chk("unexpected_calc", int'(start_calc), 0);
               end else begin
                  e = q.pop_front();
                  chk("load_sreg", int'(load_sreg), int'(!e.done));
                  chk("frame_done", int'(frame_done), int'(e.done));
                  chk("start_calc", int'(start_calc), int'(e.done));
                  if (!e.done) chk("load_pixel", int'(pixel), e.pix);
               end
            end
         end
      end
   end

   initial begin : responder
      forever begin
         @(negedge clk);
         if (resp_on) begin
            if (start_calc) cd_cnt = calc_delay;
            else if (cd_cnt >= 0) cd_cnt--;
            calc_done = (cd_cnt == 0) || (noise && ($urandom % 3 == 0));
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic pulse_req();
      frame_req = 1'b1;
      @(negedge clk);
      frame_req = 1'b0;
   endtask

   task automatic wait_pix(input int p, input string name);
      int budget;
      budget = 200;
      while (!(state_o == 2'b01 && transmit_pixel && int'(pixel) == p)
             && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin : stim
      resp_on = 1;
      cycles(3);
      rst = 1'b0;
      // continuous frames, calc answered at once
      enable = 1'b1;
      calc_delay = 0;
      cycles(2 * (FRAME + 1 + GAP) + 10);
      // single shot with a second request mid-frame
      single_shot = 1'b1;
      cycles(FRAME + GAP + 20);
      pulse_req();
      cycles(10);
      pulse_req();
      pulse_req();
      cycles(2 * (FRAME + GAP) + 20);
      // slow calculator with noise during transmit
      calc_delay = 10;
      noise = 1;
      pulse_req();
      cycles(20);
      noise = 0;
      cycles(FRAME + GAP + 20);
      // request dropped while disabled in idle
      enable = 1'b0;
      pulse_req();
      cycles(10);
      // enable dropped mid-frame
      calc_delay = 0;
      single_shot = 1'b0;
      enable = 1'b1;
      wait_pix(1, "pix1");
      enable = 1'b0;
      cycles(FRAME + GAP + 20);
      // reset during shift of pixel 2
      enable = 1'b1;
      wait_pix(2, "pix2");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cycles(FRAME + GAP + 20);
      // random phase
      for (int i = 0; i < 1500; i++) begin
         if ($urandom % 60 == 0) enable = ~enable;
         if ($urandom % 80 == 0) single_shot = ~single_shot;
         frame_req  = ($urandom % 25 == 0);
         noise      = ($urandom % 2 == 0);
         calc_delay = $urandom_range(0, 6);
         rst        = ($urandom % 700 == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      frame_req = 1'b0;
      noise = 0;
      enable = 1'b0;
      calc_delay = 0;
      cycles(FRAME + GAP + 40);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
